// File: rtl/kogge_stone_pkg.sv
// Shared constants for the Kogge-Stone adder: default operand width and prefix depth.
package kogge_stone_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  function automatic int unsigned ks_levels(input int unsigned w);
    return 32'($clog2(w));
  endfunction

  localparam int unsigned LEVELS = ks_levels(DEFAULT_WIDTH);

endpackage

// File: rtl/ks_prefix_cell.sv
// Kogge-Stone prefix operator: merges a high (g,p) span with the adjacent lower span.
module ks_prefix_cell (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g_c,
  output logic p_c
);

  assign g_c = gh | (ph & gl);
  assign p_c = ph & pl;

endmodule

// File: rtl/kogge_stone.sv
// Registered WIDTH-bit adder with carry-in; carries come from a Kogge-Stone prefix tree.
module kogge_stone
  import kogge_stone_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             out_valid
);

  localparam int unsigned LVL = ks_levels(WIDTH);

  if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("kogge_stone: WIDTH must be a power of two between 4 and 64");
  end

  logic [WIDTH-1:0] gb;
  logic [WIDTH-1:0] pb;
  logic             g0m;
  logic             p0m;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic [WIDTH-1:0] p_final_unused;

  assign gb = A & B;
  assign pb = A ^ B;

  // Cin is the bit -1 node (G=Cin, P=0); folding it into bit 0 up front lets
  // LVL levels reach from every bit all the way down to the carry-in.
  ks_prefix_cell u_cin (
    .gh  (gb[0]),
    .ph  (pb[0]),
    .gl  (Cin),
    .pl  (1'b0),
    .g_c (g0m),
    .p_c (p0m)
  );

  for (genvar k = 0; k < LVL; k++) begin : g_lvl
    localparam int unsigned SPAN = 32'(1) << k;
    logic [WIDTH-1:0] gin;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] gout;
    logic [WIDTH-1:0] pout;

    if (k == 0) begin : g_src
      assign gin = {gb[WIDTH-1:1], g0m};
      assign pin = {pb[WIDTH-1:1], p0m};
    end else begin : g_src
      assign gin = g_lvl[k-1].gout;
      assign pin = g_lvl[k-1].pout;
    end

    // Bits whose partner would lie below the carry-in already hold a complete prefix.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= SPAN) begin : g_cell
        ks_prefix_cell u_cell (
          .gh  (gin[i]),
          .ph  (pin[i]),
          .gl  (gin[i-SPAN]),
          .pl  (pin[i-SPAN]),
          .g_c (gout[i]),
          .p_c (pout[i])
        );
      end else begin : g_pass
        assign gout[i] = gin[i];
        assign pout[i] = pin[i];
      end
    end
  end

  // carry[i] is the carry into bit i; the top entry is the carry-out.
  assign carry          = {g_lvl[LVL-1].gout, Cin};
  assign p_final_unused = g_lvl[LVL-1].pout;
  assign sum_c          = pb ^ carry[WIDTH-1:0];
  assign cout_c         = carry[WIDTH];

  // Output stage: result held across idle cycles, valid strobes for one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      S         <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S    <= sum_c;
        Cout <= cout_c;
      end
    end
  end

endmodule

// File: tb/tb_kogge_stone.sv
// Directed-vector and randomised check of the registered Kogge-Stone adder.
module tb_kogge_stone;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         in_valid;
  logic [W-1:0] S;
  logic         Cout;
  logic         out_valid;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  kogge_stone #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .in_valid  (in_valid),
    .S         (S),
    .Cout      (Cout),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic apply(input logic r, input logic v, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic c);
    rst_n    = r;
    in_valid = v;
    A        = a;
    B        = b;
    Cin      = c;
    @(posedge clk);
    #1;
  endtask

  vec_t         vecs [11];
  logic [W-1:0] exp_s;
  logic         exp_c;
  logic [W:0]   ref_sum;

  initial begin
    vecs[0]  = '{a: 32'd15,         b: 32'd10,         cin: 1'b0, s: 32'd25,         cout: 1'b0};
    vecs[1]  = '{a: 32'hFFFF_FFFF,  b: 32'h0000_0000,  cin: 1'b1, s: 32'h0000_0000,  cout: 1'b1};
    vecs[2]  = '{a: 32'h8000_0000,  b: 32'h8000_0000,  cin: 1'b0, s: 32'h0000_0000,  cout: 1'b1};
    vecs[3]  = '{a: 32'h7FFF_FFFF,  b: 32'h0000_0001,  cin: 1'b0, s: 32'h8000_0000,  cout: 1'b0};
    vecs[4]  = '{a: 32'h0000_0000,  b: 32'h0000_0000,  cin: 1'b0, s: 32'h0000_0000,  cout: 1'b0};
    vecs[5]  = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  cin: 1'b1, s: 32'hFFFF_FFFF,  cout: 1'b1};
    vecs[6]  = '{a: 32'h1234_5678,  b: 32'h8765_4321,  cin: 1'b0, s: 32'h9999_9999,  cout: 1'b0};
    vecs[7]  = '{a: 32'hAAAA_AAAA,  b: 32'h5555_5555,  cin: 1'b1, s: 32'h0000_0000,  cout: 1'b1};
    vecs[8]  = '{a: 32'hDEAD_BEEF,  b: 32'h0000_0001,  cin: 1'b0, s: 32'hDEAD_BEF0,  cout: 1'b0};
    vecs[9]  = '{a: 32'hFFFF_0000,  b: 32'h0001_0000,  cin: 1'b0, s: 32'h0000_0000,  cout: 1'b1};
    vecs[10] = '{a: 32'h0000_0000,  b: 32'h0000_0000,  cin: 1'b1, s: 32'h0000_0001,  cout: 1'b0};

    // Reset wins over a valid operand presented in the same cycle.
    apply(1'b0, 1'b1, 32'd5, 32'd6, 1'b0);
    check("rst_s", 64'(S), 64'd0);
    check("rst_cout", 64'(Cout), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);

    apply(1'b1, 1'b0, 32'd5, 32'd6, 1'b0);
    check("idle_after_rst_s", 64'(S), 64'd0);
    check("idle_after_rst_cout", 64'(Cout), 64'd0);
    check("idle_after_rst_valid", 64'(out_valid), 64'd0);

    // Table vectors, applied back to back.
    for (int i = 0; i < 11; i++) begin
      apply(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
      check($sformatf("vec%0d_s", i), 64'(S), 64'(vecs[i].s));
      check($sformatf("vec%0d_cout", i), 64'(Cout), 64'(vecs[i].cout));
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
    end

    // Idle cycles hold the last result (0 + 0 + 1 = 1).
    apply(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("hold_s", 64'(S), 64'd1);
    check("hold_cout", 64'(Cout), 64'd0);
    check("hold_valid", 64'(out_valid), 64'd0);

    apply(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    check("wrap_s", 64'(S), 64'd1);
    check("wrap_cout", 64'(Cout), 64'd1);
    apply(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    check("hold_wrap_cout", 64'(Cout), 64'd1);

    // Mid-stream reset clears held state, then the first valid lands one cycle later.
    apply(1'b0, 1'b0, 32'd7, 32'd8, 1'b1);
    check("midrst_s", 64'(S), 64'd0);
    check("midrst_cout", 64'(Cout), 64'd0);
    apply(1'b1, 1'b1, 32'd15, 32'd10, 1'b0);
    check("first_after_rst_s", 64'(S), 64'd25);
    check("first_after_rst_valid", 64'(out_valid), 64'd1);

    // Random stream with gaps against a plain 33-bit reference sum.
    exp_s = 32'd25;
    exp_c = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      logic         v;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      v  = ($urandom_range(0, 3) != 0);
      ra = $urandom();
      rb = $urandom();
      rc = 1'($urandom_range(0, 1));
      if (n % 7 == 0) ra = 32'hFFFF_FFFF;
      apply(1'b1, v, ra, rb, rc);
      if (v) begin
        ref_sum = 33'(ra) + 33'(rb) + 33'(rc);
        exp_s   = ref_sum[W-1:0];
        exp_c   = ref_sum[W];
      end
      check("rand_s", 64'(S), 64'(exp_s));
      check("rand_cout", 64'(Cout), 64'(exp_c));
      check("rand_valid", 64'(out_valid), 64'(v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
